audio_feed_i2c_writer: RTL

AUDIO_FEED_I2C_WRITER -- requirements
Module: audio_feed_i2c_writer

---
 rtl/audio_feed_i2c_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/audio_feed_i2c_writer.sv
// rtl/audio_feed_i2c_writer.sv - Avalon-MM slave that writes one 3-byte I2C transaction per addr0 write.
// SCL and the SDA drive-enable are registered from next-state so they stay aligned with the FSM.
module audio_feed_i2c_writer #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        i2c_scl,
  inout  wire         i2c_sda
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  q_q, q_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] rb_q, rb_d;
  logic        nack_q, nack_d;
  logic        smp_q, smp_d;
  logic        scl_q, scl_d;
  logic        oe_q, oe_d;
  logic [31:0] readdata_q, readdata_d;

  logic wrap;
  logic busy;
  logic start_req;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:24];
  assign wrap      = (cnt_q == 12'(CLK_DIV - 1));
  assign busy      = (state_q != S_IDLE);
  assign start_req = chipselect && !write_n && (address == 2'd0) && !busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = busy ? (wrap ? 12'd0 : cnt_q + 12'd1) : 12'd0;
    q_d     = q_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    rb_d    = rb_q;
    nack_d  = nack_q;
    smp_d   = smp_q;

    case (state_q)
      S_IDLE: begin
        q_d = 2'd0;
        if (start_req) begin
          shift_d = writedata[23:0];
          rb_d    = writedata[23:0];
          nack_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          if (q_q == 2'd1) begin
            state_d = S_BIT;
            q_d     = 2'd0;
            bit_d   = 3'd7;
            byte_d  = 2'd0;
          end else begin
            q_d = q_q + 2'd1;
          end
        end
      end
      S_BIT: begin
        if (wrap) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) begin
            shift_d = {shift_q[22:0], 1'b0};
            if (bit_q == 3'd0) state_d = S_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
        end
      end
      S_ACK: begin
        if (wrap) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd2) smp_d = i2c_sda;
          if (q_q == 2'd3) begin
            // smp_q already holds the value captured at the end of q2
            if (smp_q) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else if (byte_q == 2'd2) begin
              state_d = S_STOP;
            end else begin
              byte_d  = byte_q + 2'd1;
              bit_d   = 3'd7;
              state_d = S_BIT;
            end
          end
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (q_q == 2'd2) begin
            state_d = S_IDLE;
            q_d     = 2'd0;
          end else begin
            q_d = q_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    scl_d = 1'b1;
    oe_d  = 1'b0;
    case (state_d)
      S_START: oe_d = (q_d == 2'd1);
      S_BIT: begin
        scl_d = q_d[1];
        oe_d  = !shift_d[23];
      end
      S_ACK:  scl_d = q_d[1];
      S_STOP: begin
        scl_d = (q_d != 2'd0);
        oe_d  = (q_d != 2'd2);
      end
      default: ;
    endcase

    case (address)
      2'd0:    readdata_d = {8'd0, rb_q};
      2'd1:    readdata_d = {30'd0, nack_q, busy};
      default: readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 12'd0;
      q_q        <= 2'd0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      shift_q    <= 24'd0;
      rb_q       <= 24'd0;
      nack_q     <= 1'b0;
      smp_q      <= 1'b0;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      rb_q       <= rb_d;
      nack_q     <= nack_d;
      smp_q      <= smp_d;
      scl_q      <= scl_d;
      oe_q       <= oe_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign i2c_scl  = scl_q;
  assign i2c_sda  = oe_q ? 1'b0 : 1'bz;

endmodule
